argmax_tracker: RTL and testbench

ARGMAX_TRACKER -- requirements
Module: argmax_tracker

---
 rtl/dnn_pkg.sv | 14 +
 rtl/max_finder_tree.sv | 37 +++
 rtl/argmax_tracker.sv | 130 +++++++++++++
 tb/tb_argmax_tracker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_pkg.sv
// Helpers shared by the DNN output stage: safe clog2 widths and the most-negative
// two's-complement constant for a given activation width.
package dnn_pkg;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Caller slices the low w bits; w must not exceed 64.
  function automatic logic [63:0] most_neg(input int w);
    return 64'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/max_finder_tree.sv
// N-way combinational signed argmax as a balanced binary tree, log2(N) compare stages.
// Ties go to the lower slice index at every node.
module max_finder_tree
  import dnn_pkg::*;
#(
  parameter int width = 10,
  parameter int N = 1,
  localparam int IW = clog2_min1(N)
) (
  input  logic [width*N-1:0]      act,
  output logic signed [width-1:0] max_val,
  output logic [IW-1:0]           max_idx
);

  always_comb begin
    // Heap layout: leaves at N-1..2N-2 in slice order, root at node 0.
    logic signed [width-1:0] node_val [2*N-1];
    logic [IW-1:0]           node_idx [2*N-1];
    for (int k = 0; k < N; k++) begin
      node_val[N-1+k] = act[k*width +: width];
      node_idx[N-1+k] = IW'(k);
    end
    for (int i = N - 2; i >= 0; i--) begin
      // Right child (higher indices) wins only when strictly greater.
      if (node_val[2*i+2] > node_val[2*i+1]) begin
        node_val[i] = node_val[2*i+2];
        node_idx[i] = node_idx[2*i+2];
      end else begin
        node_val[i] = node_val[2*i+1];
        node_idx[i] = node_idx[2*i+1];
      end
    end
    max_val = node_val[0];
    max_idx = node_idx[0];
  end

endmodule

// File: rtl/argmax_tracker.sv
// Tracks the running argmax of a neuron block streamed N per clock and publishes the
// predicted class at each block boundary, with correctness against the ideal one-hot.
module argmax_tracker
  import dnn_pkg::*;
#(
  parameter int width = 10,
  parameter int N = 1,
  parameter int NOUT = 16,
  parameter int SKIP = 2,
  parameter int CNT_W = 16,
  localparam int cpc = NOUT / N + SKIP
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cycle_clk,
  input  logic [clog2_min1(cpc)-1:0]   cycle_index,
  input  logic [width*N-1:0]           act_in,
  input  logic [N-1:0]                 ans_in,
  input  logic                         en,
  input  logic                         clear_counts,
  output logic [NOUT-1:0]              out_onehot,
  output logic [clog2_min1(NOUT)-1:0]  out_idx,
  output logic                         out_valid,
  output logic                         correct,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             sample_count
);

  localparam int CIW = clog2_min1(cpc);
  localparam int OIW = clog2_min1(NOUT);
  localparam int SIW = clog2_min1(N);
  localparam int LOGN = $clog2(N);
  localparam logic [63:0] MN64 = most_neg(width);
  localparam logic signed [width-1:0] MOST_NEG = MN64[width-1:0];
  localparam logic [CIW-1:0] FIRST_DATA = CIW'(SKIP);
  localparam logic [CIW-1:0] LAST_DATA = CIW'(cpc - 1);

  logic signed [width-1:0] slice_max;
  logic [SIW-1:0]          slice_idx;

  max_finder_tree #(.width(width), .N(N)) u_tree (
    .act     (act_in),
    .max_val (slice_max),
    .max_idx (slice_idx)
  );

  logic signed [width-1:0] run_max, nxt_max;
  logic [OIW-1:0]          run_idx, nxt_idx, ans_idx, nxt_ans_idx;
  logic                    ans_seen, nxt_ans_seen, seen, nxt_seen;
  logic                    armed;
  logic                    data_clk, publish, pub_correct, ans_any;
  logic [SIW-1:0]          ans_pos;
  logic [OIW-1:0]          grp, cand_idx, cand_ans;

  assign data_clk    = (cycle_index >= FIRST_DATA) && (cycle_index <= LAST_DATA);
  assign grp         = OIW'(cycle_index - FIRST_DATA);
  assign cand_idx    = (grp << LOGN) | OIW'(slice_idx);
  assign cand_ans    = (grp << LOGN) | OIW'(ans_pos);
  // armed is false until one boundary has passed, so a sample cut by reset is never published.
  assign publish     = cycle_clk && seen && armed;
  assign pub_correct = ans_seen && (ans_idx == run_idx);

  always_comb begin
    ans_any = 1'b0;
    ans_pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (ans_in[k]) begin
        ans_any = 1'b1;
        ans_pos = SIW'(k);
      end
    end
  end

  always_comb begin
    nxt_max      = cycle_clk ? MOST_NEG : run_max;
    nxt_idx      = cycle_clk ? '0 : run_idx;
    nxt_ans_idx  = cycle_clk ? '0 : ans_idx;
    nxt_ans_seen = cycle_clk ? 1'b0 : ans_seen;
    nxt_seen     = cycle_clk ? 1'b0 : seen;
    if (data_clk) begin
      nxt_seen = 1'b1;
      if (slice_max > nxt_max) begin
        nxt_max = slice_max;
        nxt_idx = cand_idx;
      end
      if (ans_any && !nxt_ans_seen) begin
        nxt_ans_seen = 1'b1;
        nxt_ans_idx  = cand_ans;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max      <= MOST_NEG;
      run_idx      <= '0;
      ans_idx      <= '0;
      ans_seen     <= 1'b0;
      seen         <= 1'b0;
      armed        <= 1'b0;
      out_onehot   <= '0;
      out_idx      <= '0;
      out_valid    <= 1'b0;
      correct      <= 1'b0;
      hit_count    <= '0;
      sample_count <= '0;
    end else begin
      run_max   <= nxt_max;
      run_idx   <= nxt_idx;
      ans_idx   <= nxt_ans_idx;
      ans_seen  <= nxt_ans_seen;
      seen      <= nxt_seen;
      armed     <= armed | cycle_clk;
      out_valid <= publish;
      if (publish) begin
        out_idx    <= run_idx;
        out_onehot <= NOUT'(1) << run_idx;
        correct    <= pub_correct;
      end
      if (clear_counts) begin
        hit_count    <= '0;
        sample_count <= '0;
      end else if (publish && en) begin
        if (sample_count != '1) sample_count <= sample_count + CNT_W'(1);
        if (pub_correct && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_argmax_tracker.sv
// Randomized bench for argmax_tracker: an N=1 instance and an N=4/CNT_W=4 instance,
// each scored against a whole-sample argmax reference model.
module tb_argmax_tracker;

  typedef logic signed [9:0] sval_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cc [2];
  logic        en_i [2];
  logic        clr [2];
  logic        rst_n [2];
  logic [4:0]  ci1;
  logic [2:0]  ci4;
  logic [9:0]  act1;
  logic [39:0] act4;
  logic [0:0]  ans1;
  logic [3:0]  ans4;

  logic [15:0] o_oh [2];
  logic [3:0]  o_idx [2];
  logic        o_vld [2];
  logic        o_cor [2];
  logic [15:0] hit1, smp1;
  logic [3:0]  hit4, smp4;

  argmax_tracker #(.width(10), .N(1), .NOUT(16), .SKIP(2), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n[0]), .cycle_clk(cc[0]), .cycle_index(ci1),
    .act_in(act1), .ans_in(ans1), .en(en_i[0]), .clear_counts(clr[0]),
    .out_onehot(o_oh[0]), .out_idx(o_idx[0]), .out_valid(o_vld[0]),
    .correct(o_cor[0]), .hit_count(hit1), .sample_count(smp1)
  );

  argmax_tracker #(.width(10), .N(4), .NOUT(16), .SKIP(2), .CNT_W(4)) dut4 (
    .clk(clk), .reset(rst_n[1]), .cycle_clk(cc[1]), .cycle_index(ci4),
    .act_in(act4), .ans_in(ans4), .en(en_i[1]), .clear_counts(clr[1]),
    .out_onehot(o_oh[1]), .out_idx(o_idx[1]), .out_valid(o_vld[1]),
    .correct(o_cor[1]), .hit_count(hit4), .sample_count(smp4)
  );

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state per instance (0: N=1, 1: N=4).
  int m_armed [2], m_pend [2], m_pidx [2], m_pcor [2];
  int m_idx [2], m_oh [2], m_cor [2], m_smp [2], m_hit [2], m_lastpub [2];
  int cmax [2] = '{65535, 15};

  function automatic int ref_argmax(input sval_t v [16]);
    int b = 0;
    for (int i = 1; i < 16; i++) if (v[i] > v[b]) b = i;
    return b;
  endfunction

  function automatic int first_ans(input logic [15:0] a);
    for (int i = 0; i < 16; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_armed[d] = 0; m_pend[d] = 0; m_idx[d] = 0; m_oh[d] = 0; m_cor[d] = 0;
    m_smp[d] = 0; m_hit[d] = 0; m_lastpub[d] = 0;
  endtask

  task automatic model_boundary(input int d, input bit en, input bit clear);
    int pub;
    pub = m_armed[d] && m_pend[d];
    m_lastpub[d] = pub;
    if (pub != 0) begin
      m_idx[d] = m_pidx[d];
      m_oh[d]  = 1 << m_pidx[d];
      m_cor[d] = m_pcor[d];
    end
    if (clear) begin
      m_smp[d] = 0; m_hit[d] = 0;
    end else if (pub != 0 && en) begin
      if (m_smp[d] < cmax[d]) m_smp[d]++;
      if (m_pcor[d] != 0 && m_hit[d] < cmax[d]) m_hit[d]++;
    end
    m_armed[d] = 1;
    m_pend[d] = 0;
  endtask

  task automatic check_outputs(input int d);
    string p;
    p = $sformatf("dut%0d", d);
    check({p, " out_valid"}, 64'(o_vld[d]), 64'(m_lastpub[d]));
    check({p, " out_idx"}, 64'(o_idx[d]), 64'(m_idx[d]));
    check({p, " out_onehot"}, 64'(o_oh[d]), 64'(m_oh[d]));
    check({p, " correct"}, 64'(o_cor[d]), 64'(m_cor[d]));
    check({p, " sample_count"}, (d == 0) ? 64'(smp1) : 64'(smp4), 64'(m_smp[d]));
    check({p, " hit_count"}, (d == 0) ? 64'(hit1) : 64'(hit4), 64'(m_hit[d]));
  endtask

  task automatic drive(input int d, input int ci, input sval_t v [16], input logic [15:0] a);
    cc[d] = (ci == 0);
    if (d == 0) begin
      ci1 = 5'(ci);
      if (ci >= 2) begin
        act1 = v[ci-2]; ans1[0] = a[ci-2];
      end else begin
        act1 = 10'($urandom); ans1[0] = 1'($urandom);
      end
    end else begin
      ci4 = 3'(ci);
      for (int k = 0; k < 4; k++) begin
        if (ci >= 2) begin
          act4[k*10 +: 10] = v[(ci-2)*4+k]; ans4[k] = a[(ci-2)*4+k];
        end else begin
          act4[k*10 +: 10] = 10'($urandom); ans4[k] = 1'($urandom);
        end
      end
    end
  endtask

  // One full block; the previous sample's publish is checked right after its boundary edge.
  task automatic run_block(input int d, input sval_t v [16], input logic [15:0] a,
                           input bit en, input bit clear, input int rst_at);
    int cpc, fa;
    cpc = (d == 0) ? 18 : 6;
    en_i[d] = en;
    for (int ci = 0; ci < cpc; ci++) begin
      @(negedge clk);
      if (ci == 1) check_outputs(d);
      if (ci == 2) check($sformatf("dut%0d valid_pulse", d), 64'(o_vld[d]), 64'(0));
      clr[d] = clear && (ci == 0);
      drive(d, ci, v, a);
      if (ci == 0) model_boundary(d, en, clear);
      if (ci == rst_at) begin
        #2 rst_n[d] = 1'b0;
        #1;
        model_reset(d);
        check_outputs(d);
        #1 rst_n[d] = 1'b1;
      end
    end
    m_pend[d] = 1;
    m_pidx[d] = ref_argmax(v);
    fa = first_ans(a);
    m_pcor[d] = (fa >= 0 && fa == m_pidx[d]) ? 1 : 0;
  endtask

  task automatic gen(output sval_t v [16], output logic [15:0] a);
    int mode, r, b;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < 16; i++) begin
      case (mode)
        0:       v[i] = 10'($urandom);
        1:       v[i] = 10'($urandom_range(0, 3));
        default: v[i] = ($urandom_range(0, 5) == 0) ? 10'($urandom) : 10'h200;
      endcase
    end
    b = ref_argmax(v);
    r = $urandom_range(0, 3);
    a = '0;
    case (r)
      0: a = '0;
      1: a[b] = 1'b1;
      2: a[$urandom_range(0, 15)] = 1'b1;
      default: begin
        a[$urandom_range(0, 15)] = 1'b1;
        a[$urandom_range(0, 15)] = 1'b1;
      end
    endcase
  endtask

  initial begin
    sval_t v [16];
    logic [15:0] a;
    for (int d = 0; d < 2; d++) begin
      cc[d] = 1'b0; en_i[d] = 1'b0; clr[d] = 1'b0; rst_n[d] = 1'b1;
      model_reset(d);
    end
    ci1 = '0; ci4 = '0; act1 = '0; act4 = '0; ans1 = '0; ans4 = '0;
    #1;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    #2;
    check_outputs(0);
    check_outputs(1);
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // N=1: single peak, answer matches.
    for (int i = 0; i < 16; i++) v[i] = 10'h000;
    v[5] = 10'h0FF; a = 16'h0020;
    run_block(0, v, a, 1'b1, 1'b0, -1);
    // Tie between neurons 3 and 9, answer on the later one.
    for (int i = 0; i < 16; i++) v[i] = 10'h000;
    v[3] = 10'h100; v[9] = 10'h100; a = 16'h0200;
    run_block(0, v, a, 1'b1, 1'b0, -1);
    // All most-negative, no answer.
    for (int i = 0; i < 16; i++) v[i] = 10'h200;
    a = 16'h0000;
    run_block(0, v, a, 1'b1, 1'b0, -1);
    // Counting disabled.
    gen(v, a);
    run_block(0, v, a, 1'b0, 1'b0, -1);
    for (int n = 0; n < 20; n++) begin
      gen(v, a);
      run_block(0, v, a, 1'($urandom), 1'b0, -1);
    end
    // Reset in the middle of a block; next boundary must stay silent.
    gen(v, a);
    run_block(0, v, a, 1'b1, 1'b0, 7);
    gen(v, a);
    run_block(0, v, a, 1'b1, 1'b0, -1);
    gen(v, a);
    run_block(0, v, a, 1'b1, 1'b0, -1);
    gen(v, a);
    run_block(0, v, a, 1'b1, 1'b0, -1);

    // N=4: single positive among negatives at neuron 14.
    for (int i = 0; i < 16; i++) v[i] = 10'h3F0;
    v[14] = 10'h050; a = 16'h4000;
    run_block(1, v, a, 1'b1, 1'b0, -1);
    // Twenty correct samples drive both 4-bit counters to saturation.
    for (int n = 0; n < 20; n++) begin
      gen(v, a);
      a = '0;
      a[ref_argmax(v)] = 1'b1;
      run_block(1, v, a, 1'b1, 1'b0, -1);
    end
    gen(v, a);
    run_block(1, v, a, 1'b1, 1'b0, -1);
    check("dut1 saturated samples", 64'(smp4), 64'(4'hF));
    check("dut1 saturated hits", 64'(hit4), 64'(4'hF));
    // Clear coinciding with a publish wins.
    gen(v, a);
    run_block(1, v, a, 1'b1, 1'b1, -1);
    for (int n = 0; n < 8; n++) begin
      gen(v, a);
      run_block(1, v, a, 1'($urandom), 1'b0, -1);
    end
    gen(v, a);
    run_block(1, v, a, 1'b1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
